apb_spi_pkt_sequencer: RTL and testbench

//  APB master that drives the APB-to-SPI bridge on behalf of the packet datapath. Sends 64-bit TX

---
 rtl/apb_spi_pkg.sv | 25 ++
 rtl/apb_master_xfer.sv | 89 ++++++++
 rtl/apb_spi_pkt_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_apb_spi_pkt_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_spi_pkg.sv
// Shared constants, CONFIG byte layout and byte-sequencer state encoding for
// the APB-to-SPI packet sequencer.
package apb_spi_pkg;
  localparam logic [15:0] CFG_ADDR  = 16'h0040;
  localparam logic [15:0] DATA_ADDR = 16'h0044;
  localparam logic [15:0] CMD_ADDR  = 16'h004C;
  localparam logic [7:0]  CMD_START = 8'h02;
  localparam logic [7:0]  PREAMBLE  = 8'hFF;

  localparam int BUSY_BIT   = 0;
  localparam int POLL_GAP   = 16;
  localparam int POLL_MAX   = 1024;
  localparam int PREADY_MAX = 64;
  localparam int TX_BYTES   = 9;
  localparam int RX_BYTES   = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_WR, S_DATA_WR, S_CMD_WR, S_POLL_RD, S_POLL_WAIT, S_RX_RD, S_NEXT
  } seq_state_e;

  function automatic logic [7:0] cfg_byte(input logic [1:0] mode, input logic [1:0] slave,
                                          input logic [1:0] sck);
    return {2'b00, mode, slave, sck};
  endfunction
endpackage

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine: SETUP, ACCESS until PREADY, then one idle cycle
// while the caller presents the next request.
module apb_master_xfer
  import apb_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  rdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [15:0] paddr,
  output logic [7:0]  pwdata,
  input  logic [7:0]  prdata,
  input  logic        pready
);
  typedef enum logic [1:0] {X_IDLE, X_SETUP, X_ACCESS} xfer_state_e;
  localparam int TW = $clog2(PREADY_MAX);

  xfer_state_e   state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          pwrite_q, pwrite_d;
  logic [15:0]   paddr_q, paddr_d;
  logic [7:0]    pwdata_q, pwdata_d;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    done     = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      X_IDLE: if (start) begin
        state_d  = X_SETUP;
        pwrite_d = write;
        paddr_d  = addr;
        pwdata_d = wdata;
      end
      X_SETUP: begin
        state_d = X_ACCESS;
        wait_d  = '0;
      end
      X_ACCESS: begin
        if (pready) begin
          done    = 1'b1;
          state_d = X_IDLE;
        end else if (wait_q == TW'(PREADY_MAX - 1)) begin
          timeout = 1'b1;
          state_d = X_IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      default: state_d = X_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= X_IDLE;
      wait_q   <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
    end
  end

  // Select/enable decode straight from state so reset drops them without a clock.
  assign psel    = (state_q != X_IDLE);
  assign penable = (state_q == X_ACCESS);
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign rdata   = prdata;
endmodule

// File: rtl/apb_spi_pkt_sequencer.sv
// Packet-level APB master for the SPI bridge: arbitrates RX service against TX
// packets and walks each SPI byte through CONFIG/TX/CMD writes and STATUS polls.
module apb_spi_pkt_sequencer
  import apb_spi_pkg::*;
(
  input  logic        i_PCLK,
  input  logic        i_PRESETn,
  input  logic [1:0]  cfg_mode,
  input  logic [1:0]  cfg_slave,
  input  logic [1:0]  cfg_sck,
  input  logic        tx_valid,
  input  logic [63:0] tx_data,
  output logic        tx_ready,
  output logic        tx_done,
  input  logic        pkt_rec,
  output logic        rx_valid,
  output logic [63:0] rx_data,
  output logic        RX_MODE,
  output logic        o_PSEL,
  output logic        o_PENABLE,
  output logic        o_PWRITE,
  output logic [15:0] o_PADDR,
  output logic [7:0]  o_PWDATA,
  input  logic [7:0]  i_PRDATA,
  input  logic        i_PREADY,
  output logic        err
);
  localparam int PCW = $clog2(POLL_MAX);
  localparam int GCW = $clog2(POLL_GAP);

  seq_state_e     state_q, state_d;
  logic [71:0]    shift_q, shift_d;
  logic [63:0]    rx_data_q, rx_data_d;
  logic [3:0]     byte_cnt_q, byte_cnt_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
  logic           rx_mode_q, rx_mode_d;
  logic           pend_q, pend_d;
  logic           pkt_rec_q;
  logic           err_q, err_d;
  logic           tx_done_q, tx_done_d;
  logic           rx_valid_q, rx_valid_d;
  logic           pkt_rise;

  logic           x_start, x_write, x_done, x_timeout;
  logic [15:0]    x_addr;
  logic [7:0]     x_wdata, x_rdata;

  apb_master_xfer u_xfer (
    .clk     (i_PCLK),
    .rst_n   (i_PRESETn),
    .start   (x_start),
    .write   (x_write),
    .addr    (x_addr),
    .wdata   (x_wdata),
    .done    (x_done),
    .timeout (x_timeout),
    .rdata   (x_rdata),
    .psel    (o_PSEL),
    .penable (o_PENABLE),
    .pwrite  (o_PWRITE),
    .paddr   (o_PADDR),
    .pwdata  (o_PWDATA),
    .prdata  (i_PRDATA),
    .pready  (i_PREADY)
  );

  assign pkt_rise = pkt_rec & ~pkt_rec_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    byte_cnt_d = byte_cnt_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rx_mode_d  = rx_mode_q;
    pend_d     = pend_q | pkt_rise;
    err_d      = err_q;
    tx_done_d  = 1'b0;
    rx_valid_d = 1'b0;
    tx_ready   = 1'b0;
    x_start    = 1'b0;
    x_write    = 1'b1;
    x_addr     = CFG_ADDR;
    x_wdata    = '0;
    case (state_q)
      S_IDLE: begin
        byte_cnt_d = '0;
        poll_cnt_d = '0;
        // A same-cycle edge counts as pending so RX wins the tie.
        if (pend_q | pkt_rise) begin
          pend_d    = 1'b0;
          rx_mode_d = 1'b1;
          state_d   = S_CFG_WR;
        end else if (tx_valid) begin
          tx_ready = 1'b1;
          shift_d  = {PREAMBLE, tx_data};
          state_d  = S_CFG_WR;
        end
      end
      S_CFG_WR: begin
        x_start = 1'b1;
        x_wdata = cfg_byte(cfg_mode, cfg_slave, cfg_sck);
        if (x_done) state_d = S_DATA_WR;
      end
      S_DATA_WR: begin
        x_start = 1'b1;
        x_addr  = DATA_ADDR;
        x_wdata = rx_mode_q ? 8'h00 : shift_q[71:64];
        if (x_done) state_d = S_CMD_WR;
      end
      S_CMD_WR: begin
        x_start = 1'b1;
        x_addr  = CMD_ADDR;
        x_wdata = CMD_START;
        if (x_done) state_d = S_POLL_RD;
      end
      S_POLL_RD: begin
        x_start = 1'b1;
        x_write = 1'b0;
        if (x_done) begin
          if (x_rdata[BUSY_BIT]) begin
            if (poll_cnt_q == PCW'(POLL_MAX - 1)) begin
              err_d     = 1'b1;
              rx_mode_d = 1'b0;
              state_d   = S_IDLE;
            end else begin
              poll_cnt_d = poll_cnt_q + PCW'(1);
              gap_cnt_d  = '0;
              state_d    = S_POLL_WAIT;
            end
          end else begin
            state_d = rx_mode_q ? S_RX_RD : S_NEXT;
          end
        end
      end
      // The engine's own idle cycle before SETUP makes up the last gap cycle.
      S_POLL_WAIT: begin
        if (gap_cnt_q == GCW'(POLL_GAP - 2)) state_d = S_POLL_RD;
        else gap_cnt_d = gap_cnt_q + GCW'(1);
      end
      S_RX_RD: begin
        x_start = 1'b1;
        x_write = 1'b0;
        x_addr  = DATA_ADDR;
        if (x_done) begin
          rx_data_d = {rx_data_q[55:0], x_rdata};
          state_d   = S_NEXT;
        end
      end
      S_NEXT: begin
        byte_cnt_d = byte_cnt_q + 4'd1;
        poll_cnt_d = '0;
        shift_d    = {shift_q[63:0], 8'h00};
        if (rx_mode_q && byte_cnt_q == 4'(RX_BYTES - 1)) begin
          rx_valid_d = 1'b1;
          rx_mode_d  = 1'b0;
          state_d    = S_IDLE;
        end else if (!rx_mode_q && byte_cnt_q == 4'(TX_BYTES - 1)) begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_CFG_WR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (x_timeout) begin
      err_d     = 1'b1;
      rx_mode_d = 1'b0;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      rx_data_q  <= '0;
      byte_cnt_q <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      rx_mode_q  <= 1'b0;
      pend_q     <= 1'b0;
      pkt_rec_q  <= 1'b0;
      err_q      <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      byte_cnt_q <= byte_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rx_mode_q  <= rx_mode_d;
      pend_q     <= pend_d;
      pkt_rec_q  <= pkt_rec;
      err_q      <= err_d;
      tx_done_q  <= tx_done_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_done  = tx_done_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign RX_MODE  = rx_mode_q;
  assign err      = err_q;
endmodule

// File: tb/tb_apb_spi_pkt_sequencer.sv
// Scoreboard bench: packet-level model pushes the expected APB/packet event
// stream; a negedge slave/monitor answers the bus and pops/compares events.
module tb_apb_spi_pkt_sequencer;
  localparam logic [15:0] CFG_A = 16'h0040, DATA_A = 16'h0044, CMD_A = 16'h004C;
  localparam int GAP = 16, PMAX = 1024;
  localparam int K_WR = 0, K_RD = 1, K_TXD = 2, K_RXV = 3;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [63:0] data;
    bit          rx;
    int          gap;
  } ev_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  cfg_mode = '0, cfg_slave = '0, cfg_sck = '0;
  logic        tx_valid = 1'b0, pkt_rec = 1'b0;
  logic [63:0] tx_data = '0;
  logic        tx_ready, tx_done, rx_valid, RX_MODE, err;
  logic [63:0] rx_data;
  logic        o_PSEL, o_PENABLE, o_PWRITE;
  logic [15:0] o_PADDR;
  logic [7:0]  o_PWDATA;
  logic [7:0]  i_PRDATA = '0;
  logic        i_PREADY = 1'b0;

  apb_spi_pkt_sequencer dut (
    .i_PCLK(clk), .i_PRESETn(rst_n), .cfg_mode(cfg_mode), .cfg_slave(cfg_slave),
    .cfg_sck(cfg_sck), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_done(tx_done), .pkt_rec(pkt_rec), .rx_valid(rx_valid), .rx_data(rx_data),
    .RX_MODE(RX_MODE), .o_PSEL(o_PSEL), .o_PENABLE(o_PENABLE), .o_PWRITE(o_PWRITE),
    .o_PADDR(o_PADDR), .o_PWDATA(o_PWDATA), .i_PRDATA(i_PRDATA), .i_PREADY(i_PREADY),
    .err(err)
  );

  always #5 clk = ~clk;

  ev_t        exp_q[$];
  bit         status_q[$];
  logic [7:0] rxb_q[$];
  int checks = 0, errors = 0;
  bit stall_en = 0, stall_all = 0;
  int stall_left = 0, idle_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [15:0] addr, input logic [63:0] data,
                         input bit rx, input int gap);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.rx = rx; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Packet model: per byte CONFIG/TX/CMD writes, busy+1 STATUS reads, RX read.
  task automatic push_pkt(input bit rx, input logic [63:0] d, input logic [7:0] cfg,
                          input int first_busy, input int max_busy);
    int nb, busy;
    logic [7:0] b;
    nb = rx ? 8 : 9;
    for (int i = 0; i < nb; i++) begin
      busy = (i == 0) ? first_busy : int'($urandom_range(0, max_busy));
      if (rx) b = d[63-8*i -: 8];
      else    b = (i == 0) ? 8'hFF : d[63-8*(i-1) -: 8];
      push_ev(K_WR, CFG_A, {56'd0, cfg}, rx, -1);
      push_ev(K_WR, DATA_A, rx ? 64'd0 : {56'd0, b}, rx, 1);
      push_ev(K_WR, CMD_A, 64'h02, rx, 1);
      for (int k = 0; k <= busy; k++) begin
        push_ev(K_RD, CFG_A, 64'd0, rx, (k == 0) ? 1 : GAP);
        status_q.push_back(k < busy);
      end
      if (rx) begin
        push_ev(K_RD, DATA_A, 64'd0, rx, 1);
        rxb_q.push_back(b);
      end
    end
    push_ev(rx ? K_RXV : K_TXD, 16'd0, rx ? d : 64'd0, 1'b0, -1);
  endtask

  task automatic check_ev(input int kind, input logic [15:0] addr, input logic [63:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, expected no event",
               kind, addr, data);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.addr != addr || ((kind == K_WR || kind == K_RXV) && e.data != data) ||
        (e.gap >= 0 && e.gap != idle_cnt) || RX_MODE !== e.rx) begin
      errors++;
      $display("FAIL event: got kind=%0d addr=%h data=%h gap=%0d rx_mode=%b, expected kind=%0d addr=%h data=%h gap=%0d rx_mode=%b",
               kind, addr, data, idle_cnt, RX_MODE, e.kind, e.addr, e.data, e.gap, e.rx);
    end
  endtask

  // APB slave + monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      i_PREADY = 1'b0; stall_left = 0; idle_cnt = 0;
    end else if (o_PSEL && !o_PENABLE) begin
      i_PREADY = 1'b0;
      stall_left = stall_en ? int'($urandom_range(0, 3)) : 0;
    end else if (o_PSEL && o_PENABLE) begin
      if (stall_all || stall_left > 0) begin
        i_PREADY = 1'b0;
        if (stall_left > 0) stall_left--;
      end else begin
        i_PREADY = 1'b1;
        if (!o_PWRITE) begin
          i_PRDATA = 8'h00;
          if (o_PADDR == CFG_A && status_q.size() != 0) i_PRDATA = {7'd0, status_q.pop_front()};
          if (o_PADDR == DATA_A && rxb_q.size() != 0) i_PRDATA = rxb_q.pop_front();
        end
        check_ev(o_PWRITE ? K_WR : K_RD, o_PADDR, {56'd0, o_PWDATA});
        idle_cnt = 0;
      end
    end else begin
      i_PREADY = 1'b0;
      idle_cnt++;
    end
    if (rst_n && tx_done)  check_ev(K_TXD, 16'd0, 64'd0);
    if (rst_n && rx_valid) check_ev(K_RXV, 16'd0, rx_data);
  end

  task automatic send_tx(input logic [63:0] d);
    int n = 0;
    @(negedge clk); tx_valid = 1'b1; tx_data = d; #1;
    while (!tx_ready && n < 3000) begin @(negedge clk); #1; n++; end
    chk("tx_accept", {63'd0, tx_ready}, 64'd1);
    @(posedge clk); #1 tx_valid = 1'b0; tx_data = '0;
  endtask

  task automatic pulse_rec();
    @(negedge clk); pkt_rec = 1'b1;
    repeat (2) @(negedge clk);
    pkt_rec = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin @(negedge clk); n++; end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_psel"}, {63'd0, o_PSEL}, 64'd0);
    chk({tag, "_penable"}, {63'd0, o_PENABLE}, 64'd0);
    chk({tag, "_pwrite"}, {63'd0, o_PWRITE}, 64'd0);
    chk({tag, "_paddr"}, {48'd0, o_PADDR}, 64'd0);
    chk({tag, "_pwdata"}, {56'd0, o_PWDATA}, 64'd0);
    chk({tag, "_tx_ready"}, {63'd0, tx_ready}, 64'd0);
    chk({tag, "_tx_done"}, {63'd0, tx_done}, 64'd0);
    chk({tag, "_rx_valid"}, {63'd0, rx_valid}, 64'd0);
    chk({tag, "_rx_data"}, rx_data, 64'd0);
    chk({tag, "_rx_mode"}, {63'd0, RX_MODE}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask

  function automatic logic [7:0] cur_cfg();
    return {2'b00, cfg_mode, cfg_slave, cfg_sck};
  endfunction

  initial begin
    logic [63:0] dtx, drx;
    bit rx;
    int n;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed TX vector: mode0 slave3 sck1 -> CONFIG 0x0D
    cfg_mode = 2'd0; cfg_slave = 2'd3; cfg_sck = 2'd1;
    push_pkt(1'b0, 64'h8123456789ABCD0F, 8'h0D, 0, 0);
    send_tx(64'h8123456789ABCD0F);
    wait_drain(3000);

    // directed RX vector
    push_pkt(1'b1, 64'h123456789ABCDEF0, 8'h0D, 0, 0);
    pulse_rec();
    wait_drain(3000);
    chk("rx_data_hold", rx_data, 64'h123456789ABCDEF0);

    // busy for three STATUS reads on the first byte
    cfg_mode = 2'd2; cfg_slave = 2'd1; cfg_sck = 2'd3;
    dtx = {$urandom, $urandom};
    push_pkt(1'b0, dtx, cur_cfg(), 3, 0);
    send_tx(dtx);
    wait_drain(5000);

    // same-cycle pkt_rec edge and tx_valid: RX served first
    drx = {$urandom, $urandom}; dtx = {$urandom, $urandom};
    push_pkt(1'b1, drx, cur_cfg(), 0, 1);
    push_pkt(1'b0, dtx, cur_cfg(), 0, 1);
    @(negedge clk); pkt_rec = 1'b1; tx_valid = 1'b1; tx_data = dtx; #1;
    chk("arb_rx_wins", {63'd0, tx_ready}, 64'd0);
    @(negedge clk);
    chk("arb_rx_mode", {63'd0, RX_MODE}, 64'd1);
    @(negedge clk); pkt_rec = 1'b0; #1;
    n = 0;
    while (!tx_ready && n < 3000) begin @(negedge clk); #1; n++; end
    chk("arb_tx_after", {63'd0, tx_ready}, 64'd1);
    @(posedge clk); #1 tx_valid = 1'b0;
    wait_drain(6000);

    // pkt_rec edge during TX: served after tx_done
    drx = {$urandom, $urandom}; dtx = {$urandom, $urandom};
    push_pkt(1'b0, dtx, cur_cfg(), 0, 1);
    push_pkt(1'b1, drx, cur_cfg(), 0, 1);
    send_tx(dtx);
    repeat (30) @(negedge clk);
    pulse_rec();
    wait_drain(6000);

    // randomized packets with PREADY stalls
    stall_en = 1;
    for (int p = 0; p < 6; p++) begin
      rx = 1'($urandom_range(0, 1));
      cfg_mode = 2'($urandom_range(0, 3)); cfg_slave = 2'($urandom_range(0, 3));
      cfg_sck = 2'($urandom_range(0, 3));
      dtx = {$urandom, $urandom};
      push_pkt(rx, dtx, cur_cfg(), int'($urandom_range(0, 2)), 2);
      if (rx) pulse_rec(); else send_tx(dtx);
      wait_drain(8000);
    end
    stall_en = 0;

    // STATUS busy forever -> err at POLL_MAX, no tx_done
    chk("err_before_stuck", {63'd0, err}, 64'd0);
    push_ev(K_WR, CFG_A, {56'd0, cur_cfg()}, 1'b0, -1);
    push_ev(K_WR, DATA_A, 64'hFF, 1'b0, 1);
    push_ev(K_WR, CMD_A, 64'h02, 1'b0, 1);
    for (int k = 0; k < PMAX; k++) begin
      push_ev(K_RD, CFG_A, 64'd0, 1'b0, (k == 0) ? 1 : GAP);
      status_q.push_back(1'b1);
    end
    send_tx({$urandom, $urandom});
    wait_drain(30000);
    repeat (10) @(negedge clk);
    chk("stuck_err", {63'd0, err}, 64'd1);
    chk("stuck_idle_psel", {63'd0, o_PSEL}, 64'd0);

    // async reset in the middle of an ACCESS phase
    stall_all = 1;
    send_tx({$urandom, $urandom});
    n = 0;
    while (!(o_PSEL && o_PENABLE) && n < 20) begin @(negedge clk); n++; end
    chk("reach_access", {63'd0, o_PSEL && o_PENABLE}, 64'd1);
    @(posedge clk); #1 rst_n = 1'b0; #1;
    chk("rst_psel_now", {63'd0, o_PSEL}, 64'd0);
    chk("rst_penable_now", {63'd0, o_PENABLE}, 64'd0);
    @(negedge clk);
    check_reset_outs("midrst");
    exp_q.delete(); status_q.delete(); rxb_q.delete();
    stall_all = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    dtx = {$urandom, $urandom};
    push_pkt(1'b0, dtx, cur_cfg(), 1, 1);
    send_tx(dtx);
    wait_drain(5000);

    // PREADY never returns -> APB timeout
    chk("err_before_timeout", {63'd0, err}, 64'd0);
    stall_all = 1;
    send_tx({$urandom, $urandom});
    repeat (80) @(negedge clk);
    chk("timeout_err", {63'd0, err}, 64'd1);
    chk("timeout_idle_psel", {63'd0, o_PSEL}, 64'd0);
    stall_all = 0;
    dtx = {$urandom, $urandom};
    push_pkt(1'b0, dtx, cur_cfg(), 0, 0);
    send_tx(dtx);
    wait_drain(3000);
    chk("err_sticky", {63'd0, err}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
